// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared NoC definitions used by the injector and the FIFO.
//   flit_t      : router-facing flit record {data, dest, is_tail} sized for the
//                 default 64-bit / 6-bit-destination configuration
//   safe_clog2  : ceil(log2(n)) that never returns 0, so that counters and
//                 pointers sized from it are always at least one bit wide
// ---------------------------------------------------------------------------
package noc_pkg;

    localparam int NOC_FLIT_WIDTH = 64;
    localparam int NOC_DEST_WIDTH = 6;

    typedef struct packed {
        logic [NOC_FLIT_WIDTH-1:0] data;
        logic [NOC_DEST_WIDTH-1:0] dest;
        logic                      is_tail;
    } flit_t;

    function automatic int safe_clog2(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// ---------------------------------------------------------------------------
// noc_sync_fifo
// Single-clock show-ahead FIFO with registered full/empty flags. The head
// entry is visible on pop_data whenever empty is low; pop consumes it.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (empties the FIFO)
//   push/push_data : write request and data (ignored while full)
//   pop/pop_data   : consume request and current head entry
//   full, empty    : registered status flags
//   full_next      : combinational "full after this edge", for callers that
//                    need a registered ready without a one-cycle lag
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module noc_sync_fifo
    import noc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             full_next
);

    localparam int AW = safe_clog2(DEPTH);
    localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             push_ok;
    logic             pop_ok;

    // Occupancy after this edge; the flags are registered from it so they
    // are exact on the same edge that changes the contents.
    always_comb begin
        push_ok    = push && !full;
        pop_ok     = pop && !empty;
        count_next = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        full_next  = (count_next == COUNT_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= full_next;
            empty <= (count_next == '0);
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/axis_flit_injector.sv
// ---------------------------------------------------------------------------
// axis_flit_injector
// AXI-Stream to NoC flit injector for a router's local input port. Beats are
// buffered, each beat is cut into SERIALIZATION_FACTOR flits (lowest slice
// first), and flits are issued under credit-based flow control.
// Ports:
//   clk_noc, rst_n       : clock, asynchronous active-low reset
//   axis_t*              : AXI-Stream slave (tready = beat FIFO not full)
//   data_out, dest_out   : flit payload and {tid, tdest} of its beat
//   is_tail_out          : last flit of the last beat of a packet
//   send_out             : one-cycle pulse per issued flit
//   credit_in            : one freed router buffer slot, pulse
// ---------------------------------------------------------------------------
module axis_flit_injector
    import noc_pkg::*;
#(
    parameter  int TDATA_WIDTH          = 64,
    parameter  int TDEST_WIDTH          = 4,
    parameter  int TID_WIDTH            = 2,
    parameter  int SERIALIZATION_FACTOR = 1,
    parameter  int BUFFER_DEPTH         = 4,
    parameter  int FLIT_BUFFER_DEPTH    = 4,
    localparam int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
    localparam int DEST_WIDTH           = TDEST_WIDTH + TID_WIDTH
) (
    input  logic                   clk_noc,
    input  logic                   rst_n,
    input  logic                   axis_tvalid,
    output logic                   axis_tready,
    input  logic [TDATA_WIDTH-1:0] axis_tdata,
    input  logic                   axis_tlast,
    input  logic [TID_WIDTH-1:0]   axis_tid,
    input  logic [TDEST_WIDTH-1:0] axis_tdest,
    output logic [FLIT_WIDTH-1:0]  data_out,
    output logic [DEST_WIDTH-1:0]  dest_out,
    output logic                   is_tail_out,
    output logic                   send_out,
    input  logic                   credit_in
);

    localparam int ENTRY_WIDTH = TDATA_WIDTH + 1 + DEST_WIDTH;
    localparam int SW          = safe_clog2(SERIALIZATION_FACTOR);
    localparam int CW          = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam logic [SW-1:0] LAST_SLICE = SW'(SERIALIZATION_FACTOR - 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(FLIT_BUFFER_DEPTH);

    logic [ENTRY_WIDTH-1:0] push_entry;
    logic [ENTRY_WIDTH-1:0] head_entry;
    logic [TDATA_WIDTH-1:0] head_data;
    logic [DEST_WIDTH-1:0]  head_dest;
    logic                   head_last;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_full_next;

    logic [SW-1:0]          slice_idx;
    logic                   last_slice;
    logic [FLIT_WIDTH-1:0]  cur_slice;
    logic [CW-1:0]          credit_cnt;
    logic [CW-1:0]          credit_next;
    logic                   issue;

    // Each FIFO entry carries the beat with its routing info: {tlast, dest, data}.
    assign push_entry = {axis_tlast, axis_tid, axis_tdest, axis_tdata};
    assign fifo_push  = axis_tvalid && axis_tready;
    assign head_data  = head_entry[TDATA_WIDTH-1:0];
    assign head_dest  = head_entry[TDATA_WIDTH +: DEST_WIDTH];
    assign head_last  = head_entry[ENTRY_WIDTH-1];

    noc_sync_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (BUFFER_DEPTH)
    ) u_beat_fifo (
        .clk       (clk_noc),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .full_next (fifo_full_next)
    );

    // A flit goes out whenever a beat is waiting and the router has room;
    // the head beat is released only once its final slice has been issued.
    always_comb begin
        issue      = !fifo_empty && (credit_cnt != '0);
        last_slice = (slice_idx == LAST_SLICE);
        fifo_pop   = issue && last_slice;
        cur_slice  = '0;
        for (int k = 0; k < SERIALIZATION_FACTOR; k++) begin
            if (slice_idx == SW'(k)) cur_slice = head_data[k*FLIT_WIDTH +: FLIT_WIDTH];
        end
    end

    // Credit bookkeeping: a returned credit and an issue in the same cycle
    // cancel. A return while already at the maximum is a router protocol
    // error; the counter saturates rather than wrapping.
    always_comb begin
        credit_next = credit_cnt;
        if (credit_in && !issue) begin
            if (credit_cnt != CREDIT_MAX) credit_next = credit_cnt + 1'b1;
        end else if (issue && !credit_in) begin
            credit_next = credit_cnt - 1'b1;
        end
    end

    // tready is registered from the FIFO's next-state fullness so it falls on
    // the same edge the FIFO fills, which keeps a push away from a full FIFO.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            slice_idx   <= '0;
            credit_cnt  <= CREDIT_MAX;
            axis_tready <= 1'b0;
        end else begin
            credit_cnt  <= credit_next;
            axis_tready <= !fifo_full_next;
            if (issue) slice_idx <= last_slice ? '0 : slice_idx + 1'b1;
        end
    end

    // Flit outputs update only on issue and otherwise hold the last flit.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            send_out    <= 1'b0;
            data_out    <= '0;
            dest_out    <= '0;
            is_tail_out <= 1'b0;
        end else begin
            send_out <= issue;
            if (issue) begin
                data_out    <= cur_slice;
                dest_out    <= head_dest;
                is_tail_out <= head_last && last_slice;
            end
        end
    end

    credit_overflow_a: assert property (@(posedge clk_noc) disable iff (!rst_n)
        !(credit_in && credit_cnt == CREDIT_MAX));

    push_when_full_a: assert property (@(posedge clk_noc) disable iff (!rst_n)
        !(fifo_push && fifo_full));

endmodule

// File: tb/tb_axis_flit_injector.sv
// ---------------------------------------------------------------------------
// tb_axis_flit_injector
// Directed bench for axis_flit_injector. Two instances share clock and reset:
// one with one flit per beat, one with four. use_sf4 steers stimulus to one
// instance and selects which instance's outputs are observed.
// ---------------------------------------------------------------------------
module tb_axis_flit_injector;

    logic        clk_noc = 1'b0;
    logic        rst_n   = 1'b0;
    logic        use_sf4 = 1'b0;
    logic        tvalid  = 1'b0;
    logic        tlast   = 1'b0;
    logic        credit  = 1'b0;
    logic [63:0] tdata   = '0;
    logic [1:0]  tid     = '0;
    logic [3:0]  tdest   = '0;

    logic        v1, v4, c1, c4;
    logic        tready1, tail1, send1;
    logic [63:0] data1;
    logic [5:0]  dest1;
    logic        tready4, tail4, send4;
    logic [15:0] data4;
    logic [5:0]  dest4;

    logic        o_ready, o_send, o_tail;
    logic [63:0] o_data;
    logic [5:0]  o_dest;
    logic [2:0]  o_credits;

    int errors = 0;
    int checks = 0;
    int idx    = 0;

    always #5 clk_noc = ~clk_noc;

    assign v1 = tvalid && !use_sf4;
    assign v4 = tvalid && use_sf4;
    assign c1 = credit && !use_sf4;
    assign c4 = credit && use_sf4;

    assign o_ready   = use_sf4 ? tready4 : tready1;
    assign o_send    = use_sf4 ? send4 : send1;
    assign o_tail    = use_sf4 ? tail4 : tail1;
    assign o_data    = use_sf4 ? {48'h0, data4} : data1;
    assign o_dest    = use_sf4 ? dest4 : dest1;
    assign o_credits = use_sf4 ? u_sf4.credit_cnt : u_sf1.credit_cnt;

    axis_flit_injector #(
        .SERIALIZATION_FACTOR (1)
    ) u_sf1 (
        .clk_noc     (clk_noc),
        .rst_n       (rst_n),
        .axis_tvalid (v1),
        .axis_tready (tready1),
        .axis_tdata  (tdata),
        .axis_tlast  (tlast),
        .axis_tid    (tid),
        .axis_tdest  (tdest),
        .data_out    (data1),
        .dest_out    (dest1),
        .is_tail_out (tail1),
        .send_out    (send1),
        .credit_in   (c1)
    );

    axis_flit_injector #(
        .SERIALIZATION_FACTOR (4)
    ) u_sf4 (
        .clk_noc     (clk_noc),
        .rst_n       (rst_n),
        .axis_tvalid (v4),
        .axis_tready (tready4),
        .axis_tdata  (tdata),
        .axis_tlast  (tlast),
        .axis_tid    (tid),
        .axis_tdest  (tdest),
        .data_out    (data4),
        .dest_out    (dest4),
        .is_tail_out (tail4),
        .send_out    (send4),
        .credit_in   (c4)
    );

    // Beat i carries 16-bit slices i*16+0 .. i*16+3, lowest slice first.
    function automatic logic [63:0] beat_data(input int i);
        logic [15:0] b;
        b = 16'(i * 16);
        return {b + 16'd3, b + 16'd2, b + 16'd1, b};
    endfunction

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic do_reset();
        tvalid = 1'b0;
        credit = 1'b0;
        idx    = 0;
        rst_n  = 1'b0;
        step();
        step();
        rst_n  = 1'b1;
    endtask

    // Offer beat idx (while idx < nbeats) for one cycle; advance on acceptance.
    task automatic stream_step(input int nbeats);
        logic rb;
        tvalid = (idx < nbeats);
        tdata  = beat_data(idx);
        tlast  = idx[0];
        tid    = 2'd1;
        tdest  = 4'(idx);
        rb     = o_ready;
        step();
        if (tvalid && rb) idx++;
    endtask

    task automatic test_reset();
        use_sf4 = 1'b0;
        rst_n   = 1'b0;
        step();
        checks++; if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_tready: got %0b expected 0", o_ready); end
        checks++; if (o_send !== 1'b0) begin errors++; $display("[TB] FAIL rst_send: got %0b expected 0", o_send); end
        checks++; if (o_tail !== 1'b0) begin errors++; $display("[TB] FAIL rst_tail: got %0b expected 0", o_tail); end
        checks++; if (o_data !== 64'h0) begin errors++; $display("[TB] FAIL rst_data: got %h expected 0", o_data); end
        checks++; if (o_dest !== 6'h0) begin errors++; $display("[TB] FAIL rst_dest: got %h expected 0", o_dest); end
        checks++; if (o_credits !== 3'd4) begin errors++; $display("[TB] FAIL rst_credits: got %0d expected 4", o_credits); end
        rst_n = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL rel_tready_pre: got %0b expected 0", o_ready); end
        step();
        checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL rel_tready_post: got %0b expected 1", o_ready); end
    endtask

    task automatic test_single_flit();
        use_sf4 = 1'b0;
        do_reset();
        step();
        tvalid = 1'b1; tdata = 64'hA5; tlast = 1'b1; tid = 2'd1; tdest = 4'd3;
        step();
        tvalid = 1'b0;
        checks++; if (o_send !== 1'b0) begin errors++; $display("[TB] FAIL t1_early_send: got %0b expected 0", o_send); end
        step();
        checks++; if (o_send !== 1'b1) begin errors++; $display("[TB] FAIL t1_send: got %0b expected 1", o_send); end
        checks++; if (o_data !== 64'hA5) begin errors++; $display("[TB] FAIL t1_data: got %h expected a5", o_data); end
        checks++; if (o_dest !== 6'h13) begin errors++; $display("[TB] FAIL t1_dest: got %h expected 13", o_dest); end
        checks++; if (o_tail !== 1'b1) begin errors++; $display("[TB] FAIL t1_tail: got %0b expected 1", o_tail); end
        step();
        checks++; if (o_send !== 1'b0) begin errors++; $display("[TB] FAIL t1_pulse: got %0b expected 0", o_send); end
    endtask

    task automatic test_serialize();
        logic [15:0] exp_slice;
        use_sf4 = 1'b1;
        do_reset();
        step();
        tvalid = 1'b1; tdata = 64'h4444_3333_2222_1111; tlast = 1'b1; tid = 2'd2; tdest = 4'd5;
        step();
        tvalid = 1'b0;
        checks++; if (o_send !== 1'b0) begin errors++; $display("[TB] FAIL t2_early_send: got %0b expected 0", o_send); end
        for (int k = 0; k < 4; k++) begin
            step();
            exp_slice = 16'(16'h1111 * (k + 1));
            checks++; if (o_send !== 1'b1) begin errors++; $display("[TB] FAIL t2_send%0d: got %0b expected 1", k, o_send); end
            checks++; if (o_data !== {48'h0, exp_slice}) begin errors++; $display("[TB] FAIL t2_data%0d: got %h expected %h", k, o_data, exp_slice); end
            checks++; if (o_tail !== (k == 3)) begin errors++; $display("[TB] FAIL t2_tail%0d: got %0b expected %0b", k, o_tail, (k == 3)); end
            checks++; if (o_dest !== 6'h25) begin errors++; $display("[TB] FAIL t2_dest%0d: got %h expected 25", k, o_dest); end
        end
        step();
        checks++; if (o_send !== 1'b0) begin errors++; $display("[TB] FAIL t2_after: got %0b expected 0", o_send); end
    endtask

    task automatic test_credit_stall();
        int sent;
        sent    = 0;
        use_sf4 = 1'b1;
        do_reset();
        step();
        for (int c = 0; c < 20; c++) begin
            stream_step(6);
            if (o_send === 1'b1) begin
                checks++; if (o_data !== 64'(sent)) begin errors++; $display("[TB] FAIL t3_data%0d: got %h expected %h", sent, o_data, 64'(sent)); end
                sent++;
            end
        end
        tvalid = 1'b0;
        checks++; if (sent != 4) begin errors++; $display("[TB] FAIL t3_sent: got %0d expected 4", sent); end
        checks++; if (o_send !== 1'b0) begin errors++; $display("[TB] FAIL t3_stalled: got %0b expected 0", o_send); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL t3_tready: got %0b expected 0", o_ready); end
        checks++; if (idx != 5) begin errors++; $display("[TB] FAIL t3_accepted: got %0d expected 5", idx); end
        credit = 1'b1;
        step();
        credit = 1'b0;
        checks++; if (o_send !== 1'b0) begin errors++; $display("[TB] FAIL t3_credit_edge: got %0b expected 0", o_send); end
        step();
        checks++; if (o_send !== 1'b1) begin errors++; $display("[TB] FAIL t3_resume: got %0b expected 1", o_send); end
        checks++; if (o_data !== 64'h10) begin errors++; $display("[TB] FAIL t3_resume_data: got %h expected 10", o_data); end
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (o_send === 1'b1) sent++;
        end
        checks++; if (sent != 0) begin errors++; $display("[TB] FAIL t3_one_only: got %0d extra flits expected 0", sent); end
    endtask

    task automatic test_back_to_back();
        logic c1q, c2q;
        int   sent, first, last;
        c1q = 1'b0; c2q = 1'b0;
        sent = 0; first = -1; last = -1;
        use_sf4 = 1'b0;
        do_reset();
        step();
        for (int c = 0; c < 30; c++) begin
            credit = c2q;
            stream_step(10);
            c2q = c1q;
            c1q = o_send;
            if (o_send === 1'b1) begin
                checks++; if (o_data !== beat_data(sent)) begin errors++; $display("[TB] FAIL t4_data%0d: got %h expected %h", sent, o_data, beat_data(sent)); end
                checks++; if (o_dest !== {2'd1, 4'(sent)}) begin errors++; $display("[TB] FAIL t4_dest%0d: got %h expected %h", sent, o_dest, {2'd1, 4'(sent)}); end
                checks++; if (o_tail !== sent[0]) begin errors++; $display("[TB] FAIL t4_tail%0d: got %0b expected %0b", sent, o_tail, sent[0]); end
                if (first < 0) first = c;
                last = c;
                sent++;
            end
            checks++; if (o_credits > 3'd4) begin errors++; $display("[TB] FAIL t4_credit_cap: got %0d expected <=4", o_credits); end
        end
        credit = 1'b0;
        checks++; if (sent != 10) begin errors++; $display("[TB] FAIL t4_sent: got %0d expected 10", sent); end
        checks++; if (last - first + 1 != 10) begin errors++; $display("[TB] FAIL t4_rate: got span %0d expected 10", last - first + 1); end
        checks++; if (o_credits !== 3'd4) begin errors++; $display("[TB] FAIL t4_credits_home: got %0d expected 4", o_credits); end
    endtask

    task automatic test_credit_collision();
        use_sf4 = 1'b0;
        do_reset();
        step();
        for (int c = 0; c < 20; c++) begin
            if (o_credits == 3'd1) break;
            stream_step(8);
        end
        checks++; if (o_credits !== 3'd1) begin errors++; $display("[TB] FAIL t5_reach_one: got %0d expected 1", o_credits); end
        credit = 1'b1;
        stream_step(8);
        credit = 1'b0;
        checks++; if (o_credits !== 3'd1) begin errors++; $display("[TB] FAIL t5_hold: got %0d expected 1", o_credits); end
        checks++; if (o_send !== 1'b1) begin errors++; $display("[TB] FAIL t5_send: got %0b expected 1", o_send); end
        stream_step(8);
        checks++; if (o_send !== 1'b1) begin errors++; $display("[TB] FAIL t5_continue: got %0b expected 1", o_send); end
        checks++; if (o_credits !== 3'd0) begin errors++; $display("[TB] FAIL t5_drain: got %0d expected 0", o_credits); end
        tvalid = 1'b0;
    endtask

    task automatic test_reset_mid_packet();
        int sent;
        sent    = 0;
        use_sf4 = 1'b1;
        do_reset();
        step();
        tvalid = 1'b1; tdata = 64'h4444_3333_2222_1111; tlast = 1'b1; tid = 2'd3; tdest = 4'd9;
        step();
        tvalid = 1'b0;
        step();
        step();
        checks++; if (o_send !== 1'b1) begin errors++; $display("[TB] FAIL t6_flit2: got %0b expected 1", o_send); end
        checks++; if (o_data !== 64'h2222) begin errors++; $display("[TB] FAIL t6_flit2_data: got %h expected 2222", o_data); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (o_send !== 1'b0) begin errors++; $display("[TB] FAIL t6_async_send: got %0b expected 0", o_send); end
        checks++; if (o_data !== 64'h0) begin errors++; $display("[TB] FAIL t6_async_data: got %h expected 0", o_data); end
        checks++; if (o_dest !== 6'h0) begin errors++; $display("[TB] FAIL t6_async_dest: got %h expected 0", o_dest); end
        checks++; if (o_tail !== 1'b0) begin errors++; $display("[TB] FAIL t6_async_tail: got %0b expected 0", o_tail); end
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (o_send === 1'b1) sent++;
        end
        checks++; if (sent != 0) begin errors++; $display("[TB] FAIL t6_no_flits: got %0d expected 0", sent); end
        checks++; if (o_credits !== 3'd4) begin errors++; $display("[TB] FAIL t6_credits: got %0d expected 4", o_credits); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL t6_tready: got %0b expected 1", o_ready); end
    endtask

    initial begin
        test_reset();
        test_single_flit();
        test_serialize();
        test_credit_stall();
        test_back_to_back();
        test_credit_collision();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
